// File: rtl/acc_exec_stage.sv
// Execute stage of the accumulator processor: takes one staged instruction per
// handshake, fetches its operand from scratch memory, updates ACC/flags and the PC.
module acc_exec_stage #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_op,
  input  logic [2:0]        instr_mode,
  input  logic [DATA_W-1:0] instr_data,
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] int_vector,
  output logic [DATA_W-1:0] acc_out,
  output logic              cout,
  output logic              zero,
  output logic              ovf,
  output logic [ADDR_W-1:0] next_pc,
  output logic              done,
  output logic              int_ack,
  output logic [ADDR_W-1:0] ret_pc,
  output logic              illegal,
  output logic [2:0]        dbgState
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [4:0] OpNop = 5'b00000;
  localparam logic [4:0] OpLda = 5'b01000;
  localparam logic [4:0] OpSta = 5'b01001;
  localparam logic [4:0] OpAdd = 5'b11000;
  localparam logic [4:0] OpSub = 5'b11001;
  localparam logic [4:0] OpAnd = 5'b11010;
  localparam logic [4:0] OpOr  = 5'b11011;
  localparam logic [4:0] OpXor = 5'b11100;
  localparam logic [4:0] OpJmp = 5'b11101;
  localparam logic [4:0] OpJz  = 5'b11110;
  localparam logic [4:0] OpJc  = 5'b11111;

  typedef enum logic [2:0] {
    Idle   = 3'd0,
    Fetch1 = 3'd1,
    Fetch2 = 3'd2,
    Exec   = 3'd3,
    Done   = 3'd4
  } state_t;

  state_t state, stateNext;

  logic [4:0]        opReg;
  logic [2:0]        modeReg;
  logic [DATA_W-1:0] dataReg;
  logic [ADDR_W-1:0] pcReg;
  logic [DATA_W-1:0] fetchReg;
  logic              illegalReg;
  logic              intTaken;

  logic [DATA_W-1:0] accReg;
  logic              coutReg, zeroReg, ovfReg;
  logic [ADDR_W-1:0] nextPcReg, retPcReg;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              accept;
  logic              useFetch;
  logic [IW-1:0]     memIdx;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W:0]   addSum, subSum;
  logic [ADDR_W-1:0] pcSeq, jumpTarget;

  logic [DATA_W-1:0] accNext;
  logic              coutNext, zeroNext, ovfNext;
  logic [ADDR_W-1:0] pcNext;
  logic              memWe, writesAcc;

  function automatic logic isLegalOp(input logic [4:0] op);
    case (op)
      OpNop, OpLda, OpSta, OpAdd, OpSub, OpAnd,
      OpOr, OpXor, OpJmp, OpJz, OpJc: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in Idle, so valid seen
  // while busy is simply not consumed and inputs are sampled only at transfer.
  assign accept = instr_valid && instr_ready;

  // Mode 2 on STA only changes the path length; the store index stays direct.
  assign useFetch   = (modeReg == 3'd1) || (modeReg == 3'd2);
  assign memIdx     = dataReg[IW-1:0];
  assign opnd       = useFetch ? fetchReg : dataReg;
  assign addSum     = {1'b0, accReg} + {1'b0, opnd};
  assign subSum     = {1'b0, accReg} + {1'b0, ~opnd} + {{DATA_W{1'b0}}, 1'b1};
  assign pcSeq      = pcReg + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign jumpTarget = ADDR_W'(opnd);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= Idle;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      Idle: begin
        if (instr_valid) begin
          if ((instr_mode == 3'd1) || (instr_mode == 3'd2)) stateNext = Fetch1;
          else                                              stateNext = Exec;
        end
      end
      Fetch1:  stateNext = (modeReg == 3'd2) ? Fetch2 : Exec;
      Fetch2:  stateNext = Exec;
      Exec:    stateNext = Done;
      Done:    stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  // Output logic
  always_comb begin
    instr_ready = (state == Idle);
    done        = (state == Done);
    int_ack     = (state == Done) && intTaken;
    illegal     = (state == Done) && illegalReg;
    dbgState    = state;
  end

  // Execute results; the jump conditions use the flags as they were before this op.
  always_comb begin
    accNext   = accReg;
    coutNext  = coutReg;
    zeroNext  = zeroReg;
    ovfNext   = ovfReg;
    pcNext    = pcSeq;
    memWe     = 1'b0;
    writesAcc = 1'b0;
    case (opReg)
      OpLda: begin
        accNext   = opnd;
        writesAcc = 1'b1;
      end
      OpSta: memWe = 1'b1;
      OpAdd: begin
        accNext   = addSum[DATA_W-1:0];
        coutNext  = addSum[DATA_W];
        ovfNext   = (accReg[DATA_W-1] == opnd[DATA_W-1]) &&
                    (addSum[DATA_W-1] != accReg[DATA_W-1]);
        writesAcc = 1'b1;
      end
      OpSub: begin
        accNext   = subSum[DATA_W-1:0];
        coutNext  = subSum[DATA_W];
        ovfNext   = (accReg[DATA_W-1] != opnd[DATA_W-1]) &&
                    (subSum[DATA_W-1] != accReg[DATA_W-1]);
        writesAcc = 1'b1;
      end
      OpAnd, OpOr, OpXor: begin
        if (opReg == OpAnd)     accNext = accReg & opnd;
        else if (opReg == OpOr) accNext = accReg | opnd;
        else                    accNext = accReg ^ opnd;
        coutNext  = 1'b0;
        ovfNext   = 1'b0;
        writesAcc = 1'b1;
      end
      OpJmp: pcNext = jumpTarget;
      OpJz:  if (zeroReg) pcNext = jumpTarget;
      OpJc:  if (coutReg) pcNext = jumpTarget;
      default: ;
    endcase
    if (writesAcc) zeroNext = (accNext == '0);
  end

  // Datapath and scratch memory
  always_ff @(posedge clk) begin
    if (reset) begin
      opReg      <= '0;
      modeReg    <= '0;
      dataReg    <= '0;
      pcReg      <= '0;
      fetchReg   <= '0;
      illegalReg <= 1'b0;
      intTaken   <= 1'b0;
      accReg     <= '0;
      coutReg    <= 1'b0;
      zeroReg    <= 1'b0;
      ovfReg     <= 1'b0;
      nextPcReg  <= '0;
      retPcReg   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        opReg      <= instr_op;
        modeReg    <= instr_mode;
        dataReg    <= instr_data;
        pcReg      <= instr_pc;
        illegalReg <= !isLegalOp(instr_op) || (instr_mode > 3'd2);
      end
      if (state == Fetch1) fetchReg <= mem[memIdx];
      if (state == Fetch2) fetchReg <= mem[fetchReg[IW-1:0]];
      if (state == Exec) begin
        accReg  <= accNext;
        coutReg <= coutNext;
        zeroReg <= zeroNext;
        ovfReg  <= ovfNext;
        if (memWe) mem[memIdx] <= accReg;
        if (int_req) begin
          nextPcReg <= int_vector;
          retPcReg  <= pcNext;
          intTaken  <= 1'b1;
        end else begin
          nextPcReg <= pcNext;
          intTaken  <= 1'b0;
        end
      end
    end
  end

  assign acc_out = accReg;
  assign cout    = coutReg;
  assign zero    = zeroReg;
  assign ovf     = ovfReg;
  assign next_pc = nextPcReg;
  assign ret_pc  = retPcReg;

endmodule

// File: tb/tb_acc_exec_stage.sv
// Bench for acc_exec_stage: a vector table drives instructions, a scoreboard
// queue holds the expected completion of each and is checked on every done pulse.
module tb_acc_exec_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid, instr_ready;
  logic [4:0] instr_op;
  logic [2:0] instr_mode;
  logic [7:0] instr_data, instr_pc;
  logic       int_req;
  logic [7:0] int_vector;
  logic [7:0] acc_out;
  logic       cout, zero, ovf;
  logic [7:0] next_pc;
  logic       done, int_ack, illegal;
  logic [7:0] ret_pc;
  logic [2:0] dbgState;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] mode;
    logic [7:0] data;
    logic [7:0] pc;
    logic       irq;
    logic [7:0] vec;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       o;
    logic [7:0] np;
    logic       ill;
    logic       ack;
    logic [7:0] ret;
    logic [2:0] lat;
  } row_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [7:0]  acc;
    logic        c;
    logic        z;
    logic        o;
    logic [7:0]  np;
    logic        ill;
    logic        ack;
    logic [7:0]  ret;
    logic [2:0]  lat;
    logic [15:0] accCyc;
  } exp_t;

  logic [$bits(exp_t)-1:0] exp_q[$];
  row_t rows[31];

  acc_exec_stage #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_mode(instr_mode),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .int_req(int_req), .int_vector(int_vector),
    .acc_out(acc_out), .cout(cout), .zero(zero), .ovf(ovf),
    .next_pc(next_pc), .done(done), .int_ack(int_ack),
    .ret_pc(ret_pc), .illegal(illegal), .dbgState(dbgState)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic [4:0] op, input logic [2:0] mode,
                              input logic [7:0] data, input logic [7:0] pc,
                              input logic irq, input logic [7:0] vec,
                              input logic [7:0] acc, input logic c, input logic z,
                              input logic o, input logic [7:0] np, input logic ill,
                              input logic ack, input logic [7:0] ret,
                              input logic [2:0] lat);
    row_t r;
    r.op = op; r.mode = mode; r.data = data; r.pc = pc; r.irq = irq; r.vec = vec;
    r.acc = acc; r.c = c; r.z = z; r.o = o; r.np = np; r.ill = ill; r.ack = ack;
    r.ret = ret; r.lat = lat;
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_ready_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  // driver: present one row, push its expectation at the accept edge
  task automatic drive(input int idx, input bit hold);
    row_t r;
    exp_t e;
    bit   rdy;
    bit   got;
    int   n;
    r = rows[idx];
    wait_ready();
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    int_req     = r.irq;
    int_vector  = r.vec;
    instr_op    = r.op;
    instr_mode  = r.mode;
    instr_data  = r.data;
    instr_pc    = r.pc;
    instr_valid = 1'b1;
    got = 1'b0;
    for (n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      rdy = instr_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
    #1;
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    e.idx = 8'(idx); e.acc = r.acc; e.c = r.c; e.z = r.z; e.o = r.o; e.np = r.np;
    e.ill = r.ill; e.ack = r.ack; e.ret = r.ret; e.lat = r.lat;
    e.accCyc = 16'(cyc - 1);  // cycle in which instr_valid was sampled
    exp_q.push_back(e);
    if (!hold) begin
      instr_valid = 1'b0;
    end else begin
      for (n = 0; n < 40 && !done; n++) @(negedge clk);
      check("hold_done_timeout", {31'd0, done}, 32'd1);
      instr_valid = 1'b0;
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  logic readyDue = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      readyDue = 1'b0;
    end else begin
      if (readyDue) check("ready_after_done", {31'd0, instr_ready}, 32'd1);
      readyDue = 1'b0;
      if (exp_q.size() != 0) check("ready_low_busy", {31'd0, instr_ready}, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check($sformatf("r%0d_acc", e.idx), {24'd0, acc_out}, {24'd0, e.acc});
          check($sformatf("r%0d_cout", e.idx), {31'd0, cout}, {31'd0, e.c});
          check($sformatf("r%0d_zero", e.idx), {31'd0, zero}, {31'd0, e.z});
          check($sformatf("r%0d_ovf", e.idx), {31'd0, ovf}, {31'd0, e.o});
          check($sformatf("r%0d_next_pc", e.idx), {24'd0, next_pc}, {24'd0, e.np});
          check($sformatf("r%0d_illegal", e.idx), {31'd0, illegal}, {31'd0, e.ill});
          check($sformatf("r%0d_int_ack", e.idx), {31'd0, int_ack}, {31'd0, e.ack});
          check($sformatf("r%0d_ret_pc", e.idx), {24'd0, ret_pc}, {24'd0, e.ret});
          check($sformatf("r%0d_latency", e.idx), 32'(cyc - int'(e.accCyc)), {29'd0, e.lat});
          readyDue = 1'b1;
        end
      end else begin
        check("int_ack_without_done", {31'd0, int_ack}, 32'd0);
        check("illegal_without_done", {31'd0, illegal}, 32'd0);
      end
    end
  end

  initial begin
    //            op     md  data   pc    irq vec    acc   c z o  np    il ak ret   lat
    rows[0]  = mk(5'h08, 0, 8'h14, 8'h01, 0, 8'h00, 8'h14, 0,0,0, 8'h02, 0, 0, 8'h00, 2);
    rows[1]  = mk(5'h08, 0, 8'h7F, 8'h02, 0, 8'h00, 8'h7F, 0,0,0, 8'h03, 0, 0, 8'h00, 2);
    rows[2]  = mk(5'h18, 0, 8'h01, 8'h03, 0, 8'h00, 8'h80, 0,0,1, 8'h04, 0, 0, 8'h00, 2);
    rows[3]  = mk(5'h18, 0, 8'h80, 8'h04, 0, 8'h00, 8'h00, 1,1,1, 8'h05, 0, 0, 8'h00, 2);
    rows[4]  = mk(5'h19, 0, 8'h01, 8'h05, 0, 8'h00, 8'hFF, 0,0,0, 8'h06, 0, 0, 8'h00, 2);
    rows[5]  = mk(5'h08, 0, 8'h05, 8'h06, 0, 8'h00, 8'h05, 0,0,0, 8'h07, 0, 0, 8'h00, 2);
    rows[6]  = mk(5'h09, 1, 8'h03, 8'h07, 0, 8'h00, 8'h05, 0,0,0, 8'h08, 0, 0, 8'h00, 3);
    rows[7]  = mk(5'h08, 0, 8'h2B, 8'h08, 0, 8'h00, 8'h2B, 0,0,0, 8'h09, 0, 0, 8'h00, 2);
    rows[8]  = mk(5'h09, 1, 8'h05, 8'h09, 0, 8'h00, 8'h2B, 0,0,0, 8'h0A, 0, 0, 8'h00, 3);
    rows[9]  = mk(5'h08, 2, 8'h03, 8'h0A, 0, 8'h00, 8'h2B, 0,0,0, 8'h0B, 0, 0, 8'h00, 4);
    rows[10] = mk(5'h08, 1, 8'h13, 8'h0B, 0, 8'h00, 8'h05, 0,0,0, 8'h0C, 0, 0, 8'h00, 3);
    rows[11] = mk(5'h1C, 0, 8'h05, 8'h0C, 0, 8'h00, 8'h00, 0,1,0, 8'h0D, 0, 0, 8'h00, 2);
    rows[12] = mk(5'h1E, 0, 8'h26, 8'h10, 0, 8'h00, 8'h00, 0,1,0, 8'h26, 0, 0, 8'h00, 2);
    rows[13] = mk(5'h08, 0, 8'h01, 8'h11, 0, 8'h00, 8'h01, 0,0,0, 8'h12, 0, 0, 8'h00, 2);
    rows[14] = mk(5'h1E, 0, 8'h26, 8'h10, 0, 8'h00, 8'h01, 0,0,0, 8'h11, 0, 0, 8'h00, 2);
    rows[15] = mk(5'h00, 0, 8'h00, 8'hFF, 0, 8'h00, 8'h01, 0,0,0, 8'h00, 0, 0, 8'h00, 2);
    rows[16] = mk(5'h07, 0, 8'h55, 8'h30, 0, 8'h00, 8'h01, 0,0,0, 8'h31, 1, 0, 8'h00, 2);
    rows[17] = mk(5'h08, 5, 8'h44, 8'h31, 0, 8'h00, 8'h44, 0,0,0, 8'h32, 1, 0, 8'h00, 2);
    rows[18] = mk(5'h1A, 0, 8'hF0, 8'h32, 0, 8'h00, 8'h40, 0,0,0, 8'h33, 0, 0, 8'h00, 2);
    rows[19] = mk(5'h18, 0, 8'hC0, 8'h33, 0, 8'h00, 8'h00, 1,1,0, 8'h34, 0, 0, 8'h00, 2);
    rows[20] = mk(5'h1F, 1, 8'h05, 8'h34, 0, 8'h00, 8'h00, 1,1,0, 8'h2B, 0, 0, 8'h00, 3);
    rows[21] = mk(5'h1B, 0, 8'h0F, 8'h35, 0, 8'h00, 8'h0F, 0,0,0, 8'h36, 0, 0, 8'h00, 2);
    rows[22] = mk(5'h1D, 0, 8'h99, 8'h36, 0, 8'h00, 8'h0F, 0,0,0, 8'h99, 0, 0, 8'h00, 2);
    rows[23] = mk(5'h18, 0, 8'h01, 8'h20, 1, 8'hC1, 8'h10, 0,0,0, 8'hC1, 0, 1, 8'h21, 2);
    rows[24] = mk(5'h1D, 0, 8'h40, 8'h50, 1, 8'hC1, 8'h10, 0,0,0, 8'hC1, 0, 1, 8'h40, 2);
    rows[25] = mk(5'h18, 0, 8'h01, 8'h21, 0, 8'h00, 8'h11, 0,0,0, 8'h22, 0, 0, 8'h40, 2);
    rows[26] = mk(5'h19, 0, 8'h11, 8'h22, 0, 8'h00, 8'h00, 1,1,0, 8'h23, 0, 0, 8'h40, 2);
    rows[27] = mk(5'h19, 0, 8'h80, 8'h23, 0, 8'h00, 8'h80, 0,0,1, 8'h24, 0, 0, 8'h40, 2);
    // after the mid-operation reset: memory, ACC and flags are back to zero
    rows[28] = mk(5'h08, 1, 8'h03, 8'h40, 0, 8'h00, 8'h00, 0,1,0, 8'h41, 0, 0, 8'h00, 3);
    rows[29] = mk(5'h08, 2, 8'h05, 8'h41, 0, 8'h00, 8'h00, 0,1,0, 8'h42, 0, 0, 8'h00, 4);
    rows[30] = mk(5'h08, 0, 8'h3C, 8'h60, 0, 8'h00, 8'h3C, 0,0,0, 8'h61, 0, 0, 8'h00, 2);

    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_mode = '0;
    instr_data = '0; instr_pc = '0; int_req = 1'b0; int_vector = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_acc", {24'd0, acc_out}, 32'd0);
    check("rst_flags", {29'd0, cout, zero, ovf}, 32'd0);
    check("rst_next_pc", {24'd0, next_pc}, 32'd0);
    check("rst_ret_pc", {24'd0, ret_pc}, 32'd0);
    check("rst_pulses", {29'd0, done, int_ack, illegal}, 32'd0);
    check("rst_state", {29'd0, dbgState}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i <= 27; i++) drive(i, 1'b0);

    // reset while the indirect load sits in its second fetch
    wait_ready();
    int_req = 1'b0; instr_op = 5'h08; instr_mode = 3'd2; instr_data = 8'h03;
    instr_pc = 8'h70; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    check("mid_f1_state", {29'd0, dbgState}, 32'd1);
    @(posedge clk); #1;
    check("mid_f2_state", {29'd0, dbgState}, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_rst_acc", {24'd0, acc_out}, 32'd0);
    check("mid_rst_flags", {29'd0, cout, zero, ovf}, 32'd0);
    check("mid_rst_next_pc", {24'd0, next_pc}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;

    drive(28, 1'b0);
    drive(29, 1'b0);
    // instr_valid held across the whole busy period must be taken only once
    drive(30, 1'b1);
    repeat (8) @(posedge clk);

    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_exec_stage.md
Name: acc_exec_stage

Overview:
- Parametrised execute stage for the accumulator processor.
- Accepts one staged instruction (opcode, address mode, data, PC) per valid/ready handshake, replacing reset-as-start sequencing.
- Supports immediate, direct and indirect operand fetch from an internal scratch memory.
- Updates ACC and the cout/zero/overflow flags, computes the next PC, and redirects to an interrupt vector on completion when requested.

Parameters:
- DATA_W, 8: accumulator, data, and memory word width.
- ADDR_W, 8: PC and vector width.
- MEM_DEPTH, 16: scratch-memory words; index width IW = clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  staged instruction present.
- instr_ready  out  1  stage can accept; high only in IDLE.
- instr_op  in  5  opcode.
- instr_mode  in  3  address mode.
- instr_data  in  DATA_W  immediate value or memory index.
- instr_pc  in  ADDR_W  PC of the instruction.
- int_req  in  1  level interrupt request.
- int_vector  in  ADDR_W  interrupt target address.
- acc_out  out  DATA_W  accumulator.
- cout  out  1  carry flag register.
- zero  out  1  zero flag register.
- ovf  out  1  overflow flag register.
- next_pc  out  ADDR_W  registered next PC.
- done  out  1  one-cycle completion pulse; next_pc is valid in this cycle.
- int_ack  out  1  one-cycle pulse, coincident with done, when the interrupt is taken.
- ret_pc  out  ADDR_W  return PC saved when the interrupt is taken.
- illegal  out  1  one-cycle pulse with done for an undefined opcode or mode.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - all outputs 0, except instr_ready = 1;
  - all memory words 0;
  - state IDLE.
- Opcodes:
  - 00000 NOP.
  - 01000 LDA: ACC = opnd.
  - 01001 STA: mem[idx] = ACC.
  - 11000 ADD: ACC = ACC + opnd.
  - 11001 SUB: ACC = ACC + ~opnd + 1.
  - 11010 AND.
  - 11011 OR.
  - 11100 XOR.
  - 11101 JMP: next_pc = opnd[ADDR_W-1:0], zero-extended.
  - 11110 JZ: jump if zero.
  - 11111 JC: jump if cout.
  - Any other opcode: executes as NOP and pulses illegal.
- Address modes:
  - 0 immediate: opnd = instr_data.
  - 1 direct: opnd = mem[instr_data[IW-1:0]].
  - 2 indirect: opnd = mem[mem[instr_data[IW-1:0]][IW-1:0]].
  - Modes 3-7: treated as immediate and pulse illegal.
  - Upper index bits are ignored.
- STA address: idx is the direct index in modes 1 and 2 (indirect for STA = direct); STA in mode 0 stores to index instr_data[IW-1:0].
- Memory: asynchronous read; write occurs on the EXEC edge.
- FSM: IDLE -> (F1 if mode 1/2) -> (F2 if mode 2) -> EXEC -> DONE -> IDLE.
  - IDLE: latch op, mode, data and pc on instr_valid & instr_ready.
  - F1, F2: each latches one memory read.
  - EXEC: registers ACC, flags, memory write and next_pc.
  - DONE: asserts done for exactly one cycle.
- Latency from the accept edge to done high: immediate 2 cycles, direct 3, indirect 4.
- Back-to-back: instr_ready rises in the cycle after DONE; minimum issue interval is 3 cycles.
- Handshake: instr_valid while busy is ignored; inputs are sampled only at accept.
- Flags:
  - zero: updated on every ACC-writing op (LDA, ADD, SUB, AND, OR, XOR).
  - ADD: cout = carry out of the MSB.
  - SUB: cout = 1 when no borrow (ACC >= opnd, unsigned).
  - ovf (ADD/SUB): signed overflow, computed from operand and result MSBs.
  - AND/OR/XOR clear cout and ovf.
  - LDA holds cout and ovf.
  - STA, jumps and NOP hold all flags.
  - JZ and JC test the flag values before the instruction.
- PC: sequential next_pc = instr_pc + 1 mod 2^ADDR_W, so 0xFF wraps to 0x00.
- Interrupt:
  - int_req is sampled in EXEC; if high, next_pc = int_vector and ret_pc = the computed next_pc (sequential or jump target).
  - int_ack pulses in DONE.
  - int_req at any other time is ignored and must be held to be taken.
- Reset mid-operation: the FSM returns to IDLE, no done pulse is issued, any pending STA is not committed, and state and memory clear.

Test Plan:
1. Reset; LDA mode 0 data 20, pc 0x01 -> acc_out 0x14, zero 0, done exactly 2 cycles after accept, next_pc 0x02, instr_ready low throughout.
2. LDA 0x7F; ADD imm 0x01 -> acc 0x80, ovf 1, cout 0. Then ADD imm 0x80 -> acc 0x00, cout 1, zero 1, ovf 1. Then SUB imm 0x01 -> acc 0xFF, cout 0, zero 0.
3. LDA 5; STA mode 1 data 3; LDA 0x2B; STA mode 1 data 5; LDA mode 2 data 3 -> acc 0x2B, done 4 cycles after accept; LDA mode 1 data 0x13 -> reads index 3 -> acc 0x05.
4. With zero 1: JZ imm 0x26, pc 0x10 -> next_pc 0x26. With zero 0 -> next_pc 0x11. NOP at pc 0xFF -> next_pc 0x00. Opcode 00111 -> illegal pulse, ACC and flags unchanged.
5. int_req held high during ADD at pc 0x20, int_vector 0xC1 -> next_pc 0xC1, int_ack one cycle coincident with done, ret_pc 0x21.
6. Reset asserted during F2 of an indirect LDA -> no done, acc 0, memory 0, instr_ready 1 the cycle after reset; instr_valid held while busy is accepted only once.
